// File: rtl/decode_redirect_if.sv
// Fetch/decode handshake bundle between the fetch stage and the ID redirect unit.
// The master side drives fetch inputs; the slave side is the decode_redirect block.
interface decode_redirect_if;
    logic [63:0] cur_pc;
    logic [31:0] instruction;
    logic        stall_in;
    logic [63:0] rt_value;
    logic [63:0] branch_target;
    logic        pc_src;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic [15:0] flush_count;

    modport master (
        output cur_pc, instruction, stall_in, rt_value,
        input  branch_target, pc_src, id_pc, id_instr, id_valid, flush_count
    );

    modport slave (
        input  cur_pc, instruction, stall_in, rt_value,
        output branch_target, pc_src, id_pc, id_instr, id_valid, flush_count
    );
endinterface

// File: rtl/decode_redirect.sv
// ID-stage register with B/CBZ/CBNZ resolution, stall handling and single-cycle
// fetch redirects; every redirect is followed by exactly one bubble cycle.
module decode_redirect #(
    parameter logic [31:0] NOP = 32'hD503201F
) (
    input logic          clk,
    input logic          reset,
    decode_redirect_if.slave bus
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [63:0] id_pc_p0;
    logic [31:0] id_instr_p0;
    logic        id_valid_p0;
    logic [15:0] flush_count_p0;

    logic        is_b, is_cbz, is_cbnz, taken;
    logic signed [63:0] offset;
    logic [63:0] taken_tgt;
    logic        capture, bubble;

    function automatic logic signed [63:0] b_offset(input logic [31:0] instr);
        return {{36{instr[25]}}, instr[25:0], 2'b00};
    endfunction

    function automatic logic signed [63:0] cb_offset(input logic [31:0] instr);
        return {{43{instr[23]}}, instr[23:5], 2'b00};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    always_comb begin
        is_b      = (id_instr_p0[31:26] == 6'b000101);
        is_cbz    = (id_instr_p0[31:24] == 8'hB4);
        is_cbnz   = (id_instr_p0[31:24] == 8'hB5);
        offset    = is_b ? b_offset(id_instr_p0) : cb_offset(id_instr_p0);
        taken_tgt = id_pc_p0 + 64'(offset);
        taken     = id_valid_p0 && (is_b ||
                                    (is_cbz  && (bus.rt_value == 64'd0)) ||
                                    (is_cbnz && (bus.rt_value != 64'd0)));
    end

    // Next-state and redirect decision; pc_src never repeats because redirects always go to FLUSH.
    always_comb begin
        state_nxt         = state;
        bus.pc_src        = 1'b0;
        bus.branch_target = 64'd0;
        capture           = 1'b0;
        bubble            = 1'b0;
        case (state)
            RUN: begin
                if (!id_valid_p0) begin
                    capture = 1'b1;
                end else if (bus.stall_in) begin
                    state_nxt = STALL;
                end else if (taken) begin
                    bus.pc_src        = 1'b1;
                    bus.branch_target = taken_tgt;
                    bubble            = 1'b1;
                    state_nxt         = FLUSH;
                end else begin
                    capture = 1'b1;
                end
            end
            STALL: begin
                // Fetch kept running while stalled, so always redirect: either to the target or a replay of id_pc+4.
                if (!bus.stall_in) begin
                    bus.pc_src        = 1'b1;
                    bus.branch_target = taken ? taken_tgt : id_pc_p0 + 64'd4;
                    bubble            = 1'b1;
                    state_nxt         = FLUSH;
                end
            end
            FLUSH: begin
                capture   = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // ---- ID register stage ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            id_valid_p0    <= 1'b0;
            id_pc_p0       <= 64'd0;
            id_instr_p0    <= NOP;
            flush_count_p0 <= 16'd0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                id_pc_p0    <= bus.cur_pc;
                id_instr_p0 <= bus.instruction;
                id_valid_p0 <= 1'b1;
            end else if (bubble) begin
                id_valid_p0 <= 1'b0;
            end
            if (bubble) begin
                flush_count_p0 <= sat_inc(flush_count_p0);
            end
        end
    end

    assign bus.id_pc       = id_pc_p0;
    assign bus.id_instr    = id_valid_p0 ? id_instr_p0 : NOP;
    assign bus.id_valid    = id_valid_p0;
    assign bus.flush_count = flush_count_p0;

endmodule
